tlc1543_emu: RTL and testbench

- Synthesizable slave-side emulator of the TLC1543 10-bit serial ADC; the responder end of the TLC1543 serial interface.
- Lets the TLC1543 master controller be exercised on-board or in simulation without the physical ADC (hardware-in-loop, bring-up).
- Samples the master's I/O clock, CS_n and address lines; shifts out the previous conversion result MSB-first; emulates conversion time on EOC.
- Channel values come from an external source through a simple select/value port.

---
 rtl/tlc1543_pkg.sv | 47 ++++
 rtl/tlc1543_sync_edge.sv | 31 +++
 rtl/tlc1543_emu.sv | 147 ++++++++++++++
 tb/tb_tlc1543_emu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc1543_pkg.sv
// Shared constants, state encoding and result helpers for the TLC1543 slave emulator.
package tlc1543_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SHIFT   = 2'd1;
  localparam state_t ST_CONVERT = 2'd2;

  localparam logic [3:0] FRAME_LEN = 4'd10;
  localparam logic [3:0] ADDR_LEN  = 4'd4;

  localparam logic [3:0] ADDR_LAST_CH   = 4'hA;
  localparam logic [3:0] ADDR_TEST_MID  = 4'hB;
  localparam logic [3:0] ADDR_TEST_ZERO = 4'hC;
  localparam logic [3:0] ADDR_TEST_FULL = 4'hD;

  localparam logic [9:0] RESULT_MID_DEFAULT = 10'h200;
  localparam logic [9:0] RESULT_ZERO        = '0;
  localparam logic [9:0] RESULT_FULL        = '1;

  // Bit n of the frame, counted from the MSB.
  function automatic logic frame_bit(input logic [9:0] r, input logic [3:0] n);
    logic [9:0] s;
    s = r << n;
    return s[9];
  endfunction

  function automatic logic [9:0] conv_result(input logic [3:0] addr,
                                             input logic [9:0] ch_val,
                                             input logic [9:0] mid);
    logic [9:0] r;
    r = RESULT_ZERO;
    if (addr <= ADDR_LAST_CH) begin
      r = ch_val;
    end else begin
      case (addr)
        ADDR_TEST_MID:  r = mid;
        ADDR_TEST_ZERO: r = RESULT_ZERO;
        ADDR_TEST_FULL: r = RESULT_FULL;
        default:        r = RESULT_ZERO;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/tlc1543_sync_edge.sv
// Multi-stage synchronizer for an asynchronous master line, with rise/fall pulses.
module tlc1543_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/tlc1543_emu.sv
// Slave-side TLC1543 emulator: shifts out the previous result, emulates conversion time on EOC.
module tlc1543_emu
  import tlc1543_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 1050,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [9:0]  TEST_MID    = RESULT_MID_DEFAULT
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       cs_n_in,
  input  logic       addr_in,
  output logic       data_out,
  output logic       eoc_out,
  output logic [3:0] ch_sel,
  input  logic [9:0] ch_value,
  output logic       conv_done,
  output logic       frame_err
);

  localparam int unsigned           CONV_W    = $clog2(CONV_CYCLES + 1);
  localparam logic [CONV_W-1:0]     CONV_LAST = CONV_W'(CONV_CYCLES - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic addr_lvl, addr_rise, addr_fall;
  logic unused_sync;

  tlc1543_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_50m(clk_50m), .rst_n(rst_n), .din(sclk_in),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  tlc1543_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_50m(clk_50m), .rst_n(rst_n), .din(cs_n_in),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  tlc1543_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_addr (
    .clk_50m(clk_50m), .rst_n(rst_n), .din(addr_in),
    .level(addr_lvl), .rise(addr_rise), .fall(addr_fall)
  );

  assign unused_sync = ^{sclk_lvl, addr_rise, addr_fall};

  state_t            state_q;
  logic [3:0]        bit_cnt_q;
  logic [3:0]        addr_sh_q;
  logic [9:0]        result_q;
  logic [CONV_W-1:0] conv_cnt_q;
  logic              pend_q;
  logic              pend_ovr_q;
  logic [3:0]        bit_nxt;
  logic [9:0]        new_result;

  assign bit_nxt    = (bit_cnt_q == FRAME_LEN) ? bit_cnt_q : bit_cnt_q + 4'd1;
  assign new_result = conv_result(ch_sel, ch_value, TEST_MID);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      addr_sh_q  <= '0;
      result_q   <= '0;
      conv_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_ovr_q <= 1'b0;
      data_out   <= 1'b0;
      eoc_out    <= 1'b1;
      ch_sel     <= '0;
      conv_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            bit_cnt_q <= '0;
            data_out  <= result_q[9];
            state_q   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            if (sclk_rise && (bit_cnt_q < ADDR_LEN)) begin
              addr_sh_q <= {addr_sh_q[2:0], addr_lvl};
            end
            if (sclk_fall) begin
              bit_cnt_q <= bit_nxt;
              if (bit_nxt < FRAME_LEN) begin
                data_out <= frame_bit(result_q, bit_nxt);
              end else begin
                ch_sel     <= addr_sh_q;
                eoc_out    <= 1'b0;
                conv_cnt_q <= '0;
                pend_q     <= 1'b0;
                pend_ovr_q <= 1'b0;
                state_q    <= ST_CONVERT;
              end
            end
          end
        end

        ST_CONVERT: begin
          conv_cnt_q <= conv_cnt_q + 1'b1;
          if (conv_cnt_q == CONV_LAST) begin
            result_q   <= new_result;
            eoc_out    <= 1'b1;
            conv_done  <= 1'b1;
            pend_q     <= 1'b0;
            pend_ovr_q <= 1'b0;
            bit_cnt_q  <= '0;
            // A pending frame that already clocked bits on the old result cannot restart cleanly.
            if (!cs_lvl && !(pend_q && (bit_cnt_q != 4'd0))) begin
              data_out <= new_result[9];
              state_q  <= ST_SHIFT;
            end else begin
              state_q  <= ST_IDLE;
            end
          end else if (cs_fall) begin
            pend_q     <= 1'b1;
            pend_ovr_q <= 1'b0;
            bit_cnt_q  <= '0;
            data_out   <= result_q[9];
          end else if (cs_rise) begin
            pend_q <= 1'b0;
          end else if (pend_q && !pend_ovr_q && sclk_fall) begin
            bit_cnt_q <= bit_nxt;
            if (bit_nxt < FRAME_LEN) begin
              data_out <= frame_bit(result_q, bit_nxt);
            end else begin
              frame_err  <= 1'b1;
              pend_ovr_q <= 1'b1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc1543_emu.sv
// Self-checking bench for tlc1543_emu: emulated master frames with a scoreboard of expected reads.
module tb_tlc1543_emu;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sclk_in = 1'b0;
  logic       cs_n_in = 1'b1;
  logic       addr_in = 1'b0;
  logic       data_out, eoc_out, conv_done, frame_err;
  logic [3:0] ch_sel;
  logic [9:0] ch_value;
  logic [9:0] chan_val [16];

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] sb [$];
  logic [9:0] model_result = 10'h000;

  int   run_len = 0, low_periods = 0, last_low = 0;
  int   cd_pulses = 0, cd_orphans = 0, fe_pulses = 0, fe_high = 0;
  logic prev_eoc = 1'b1, prev_fe = 1'b0;

  always #10 clk_50m = ~clk_50m;

  assign ch_value = chan_val[ch_sel];

  tlc1543_emu #(.CONV_CYCLES(1050), .SYNC_STAGES(2), .TEST_MID(10'h200)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
    .addr_in(addr_in), .data_out(data_out), .eoc_out(eoc_out), .ch_sel(ch_sel),
    .ch_value(ch_value), .conv_done(conv_done), .frame_err(frame_err)
  );

  always @(negedge clk_50m) begin
    if (eoc_out === 1'b0) run_len++;
    else if (run_len > 0) begin last_low = run_len; low_periods++; run_len = 0; end
    if (conv_done === 1'b1) begin
      cd_pulses++;
      if (!(eoc_out === 1'b1 && prev_eoc === 1'b0)) cd_orphans++;
    end
    if (frame_err === 1'b1) begin
      fe_high++;
      if (prev_fe !== 1'b1) fe_pulses++;
    end
    prev_eoc = eoc_out;
    prev_fe  = frame_err;
  end

  function automatic logic [9:0] exp_val(input logic [3:0] a);
    if (a <= 4'hA) return chan_val[a];
    case (a)
      4'hB:    return 10'h200;
      4'hD:    return 10'h3FF;
      default: return 10'h000;
    endcase
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic master_frame(input logic [3:0] addr, input int nfall, output logic [9:0] rd);
    rd = '0;
    @(negedge clk_50m);
    cs_n_in = 1'b0;
    wait_cycles(6);
    for (int i = 0; i < nfall; i++) begin
      addr_in = (i < 4) ? addr[3-i] : 1'b0;
      wait_cycles(5);
      sclk_in = 1'b1;
      wait_cycles(4);
      rd[9-i] = data_out;
      wait_cycles(1);
      sclk_in = 1'b0;
    end
    wait_cycles(8);
    cs_n_in = 1'b1;
    addr_in = 1'b0;
    wait_cycles(8);
  endtask

  task automatic wait_conv(input string name);
    int start;
    start = low_periods;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50m);
      if (low_periods != start) break;
    end
    vectors++;
    if (low_periods == start) begin
      miscompares++;
      $display("FAIL %s_conv_timeout: eoc low periods got %0d required %0d", name, low_periods, start + 1);
    end
    wait_cycles(5);
  endtask

  task automatic test_reset;
    wait_cycles(3);
    vectors++; if (eoc_out !== 1'b1) begin miscompares++; $display("FAIL reset_eoc: got %b required 1", eoc_out); end
    vectors++; if (data_out !== 1'b0) begin miscompares++; $display("FAIL reset_data: got %b required 0", data_out); end
    vectors++; if (ch_sel !== 4'h0) begin miscompares++; $display("FAIL reset_ch_sel: got %h required 0", ch_sel); end
    vectors++; if (conv_done !== 1'b0) begin miscompares++; $display("FAIL reset_conv_done: got %b required 0", conv_done); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    rst_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_two_frames;
    logic [9:0] rd, exp;
    int cd0;
    chan_val[2] = 10'h155;
    for (int f = 0; f < 2; f++) begin
      cd0 = cd_pulses;
      sb.push_back(model_result);
      master_frame(4'h2, 10, rd);
      exp = sb.pop_front();
      vectors++; if (rd !== exp) begin miscompares++; $display("FAIL two_frames_read%0d: got %h required %h", f, rd, exp); end
      wait_conv("two_frames");
      model_result = exp_val(4'h2);
      vectors++; if (last_low != 1050) begin miscompares++; $display("FAIL two_frames_eoc_len%0d: got %0d required 1050", f, last_low); end
      vectors++; if (ch_sel !== 4'h2) begin miscompares++; $display("FAIL two_frames_ch_sel%0d: got %h required 2", f, ch_sel); end
      vectors++; if (cd_pulses != cd0 + 1) begin miscompares++; $display("FAIL two_frames_conv_done%0d: got %0d required %0d", f, cd_pulses, cd0 + 1); end
    end
  endtask

  task automatic test_reset_mid_conv;
    logic [9:0] rd, exp;
    int i;
    chan_val[0] = 10'h2AA;
    sb.push_back(model_result);
    master_frame(4'h2, 10, rd);
    exp = sb.pop_front();
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL rstmid_pre_read: got %h required %h", rd, exp); end
    for (i = 0; i < 2000; i++) begin
      if (run_len >= 100) break;
      @(negedge clk_50m);
    end
    vectors++; if (run_len < 100) begin miscompares++; $display("FAIL rstmid_wait: eoc low run got %0d required >=100", run_len); end
    rst_n = 1'b0;
    #1;
    vectors++; if (eoc_out !== 1'b1) begin miscompares++; $display("FAIL rstmid_eoc: got %b required 1", eoc_out); end
    vectors++; if (data_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_data: got %b required 0", data_out); end
    wait_cycles(4);
    rst_n = 1'b1;
    model_result = 10'h000;
    wait_cycles(5);
    sb.push_back(model_result);
    master_frame(4'h0, 10, rd);
    exp = sb.pop_front();
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL rstmid_post_read: got %h required %h", rd, exp); end
    wait_conv("rstmid");
    model_result = exp_val(4'h0);
  endtask

  task automatic test_alternating;
    logic [9:0] rd, exp;
    logic [3:0] seq [4];
    seq = '{4'hA, 4'h2, 4'hA, 4'h2};
    chan_val[10] = 10'h3C0;
    chan_val[2]  = 10'h00F;
    for (int f = 0; f < 4; f++) begin
      sb.push_back(model_result);
      master_frame(seq[f], 10, rd);
      exp = sb.pop_front();
      vectors++; if (rd !== exp) begin miscompares++; $display("FAIL alternating_read%0d: got %h required %h", f, rd, exp); end
      wait_conv("alternating");
      model_result = exp_val(seq[f]);
    end
  endtask

  task automatic test_selftest;
    logic [9:0] rd, exp;
    logic [3:0] seq [5];
    seq = '{4'hB, 4'hC, 4'hD, 4'hE, 4'h0};
    for (int k = 11; k < 16; k++) chan_val[k] = 10'h1A5;
    chan_val[0] = 10'h0F0;
    for (int f = 0; f < 5; f++) begin
      sb.push_back(model_result);
      master_frame(seq[f], 10, rd);
      exp = sb.pop_front();
      vectors++; if (rd !== exp) begin miscompares++; $display("FAIL selftest_read%0d: got %h required %h", f, rd, exp); end
      wait_conv("selftest");
      model_result = exp_val(seq[f]);
    end
  endtask

  task automatic test_abort;
    logic [9:0] rd, exp;
    int fp0, fh0, lp0;
    chan_val[5] = 10'h1C3;
    fp0 = fe_pulses; fh0 = fe_high; lp0 = low_periods;
    master_frame(4'h5, 6, rd);
    vectors++; if (fe_pulses != fp0 + 1) begin miscompares++; $display("FAIL abort_fe_pulses: got %0d required %0d", fe_pulses - fp0, 1); end
    vectors++; if (fe_high != fh0 + 1) begin miscompares++; $display("FAIL abort_fe_width: got %0d required 1", fe_high - fh0); end
    vectors++; if (low_periods != lp0 || eoc_out !== 1'b1) begin miscompares++; $display("FAIL abort_eoc: got periods %0d eoc %b required 0 and 1", low_periods - lp0, eoc_out); end
    vectors++; if (rd[9:4] !== model_result[9:4]) begin miscompares++; $display("FAIL abort_partial_read: got %h required %h", rd[9:4], model_result[9:4]); end
    sb.push_back(model_result);
    master_frame(4'h5, 10, rd);
    exp = sb.pop_front();
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL abort_next_read: got %h required %h", rd, exp); end
    wait_conv("abort");
    model_result = exp_val(4'h5);
  endtask

  task automatic test_overrun;
    logic [9:0] rd, exp;
    int fp0, lp0, cd0, i;
    chan_val[7] = 10'h2E1;
    chan_val[3] = 10'h11D;
    sb.push_back(model_result);
    master_frame(4'h7, 10, rd);
    exp = sb.pop_front();
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL overrun_first_read: got %h required %h", rd, exp); end
    for (i = 0; i < 2000; i++) begin
      if (run_len >= 200) break;
      @(negedge clk_50m);
    end
    vectors++; if (run_len < 200) begin miscompares++; $display("FAIL overrun_wait: eoc low run got %0d required >=200", run_len); end
    fp0 = fe_pulses; lp0 = low_periods; cd0 = cd_pulses;
    sb.push_back(model_result);
    master_frame(4'h3, 10, rd);
    exp = sb.pop_front();
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL overrun_pending_read: got %h required %h", rd, exp); end
    vectors++; if (fe_pulses != fp0 + 1) begin miscompares++; $display("FAIL overrun_fe: got %0d required 1", fe_pulses - fp0); end
    wait_conv("overrun");
    model_result = exp_val(4'h7);
    vectors++; if (last_low != 1050) begin miscompares++; $display("FAIL overrun_eoc_len: got %0d required 1050", last_low); end
    vectors++; if (cd_pulses != cd0 + 1) begin miscompares++; $display("FAIL overrun_conv_done: got %0d required 1", cd_pulses - cd0); end
    wait_cycles(2000);
    vectors++; if (low_periods != lp0 + 1 || eoc_out !== 1'b1) begin miscompares++; $display("FAIL overrun_second_conv: got periods %0d eoc %b required 1 and 1", low_periods - lp0, eoc_out); end
    sb.push_back(model_result);
    master_frame(4'h0, 10, rd);
    exp = sb.pop_front();
    vectors++; if (rd !== exp) begin miscompares++; $display("FAIL overrun_after_read: got %h required %h", rd, exp); end
    wait_conv("overrun_after");
    model_result = exp_val(4'h0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) chan_val[k] = 10'h000;
    test_reset();
    test_two_frames();
    test_reset_mid_conv();
    test_alternating();
    test_selftest();
    test_abort();
    test_overrun();
    vectors++; if (cd_orphans != 0) begin miscompares++; $display("FAIL conv_done_vs_eoc: got %0d orphan pulses required 0", cd_orphans); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
